// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared definitions for the bit-serial adder controller
//
// Purpose : default operand width and FSM state codes shared by the
//           controller, its bus interface and any wrapper that needs them.
// Ports   : none (package).

package serial_adder_ctrl_pkg;

   // Default operand/sum width; legal range is 1..16.
   localparam int DEF_WIDTH = 4;

   // FSM state codes. Code 3 is unused and recovers to IDLE.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result bus between a client and the serial adder
//
// Purpose : groups the start/operand request and the busy/done/result
//           response of serial_adder_ctrl.
// Ports   : start, a, b      client -> adder
//           busy, done,
//           sum, cout        adder  -> client
// Modports: master (client side), slave (adder side).

interface serial_adder_ctrl_if
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell
//
// Purpose : s = a ^ b, c = a & b.
// Ports   : a, b  inputs
//           s     sum output
//           c     carry output

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl_full_adder_ha.sv
// rtl/serial_adder_ctrl_full_adder_ha.sv - full adder built from two half adders
//
// Purpose : combinational one-bit full adder; two half_adder cells plus an
//           OR to merge their carries.
// Ports   : a, b, cin  inputs
//           s          sum bit
//           cout       carry out (majority of a, b, cin)

module full_adder_ha (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (cin),
      .s (s),
      .c (c1)
   );

   // The two half-adder carries can never both be 1, so OR equals majority.
   assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder controller
//
// Purpose : captures a/b on an accepted start, adds one bit per clock LSB
//           first through a single full_adder_ha, then publishes sum/cout
//           and pulses done for one cycle.
// Ports   : clk    system clock, rising edge
//           reset  synchronous, active-high
//           bus    serial_adder_ctrl_if.slave
//                    start/a/b in, busy/done/sum/cout out

module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   serial_adder_ctrl_if.slave      bus
);

   localparam int                 CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;

   full_adder_ha u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB so after WIDTH shifts the LSB result
   // has walked down to bit 0. A one-bit accumulator is just the sum bit.
   generate
      if (WIDTH == 1) begin : g_acc_w1
         assign acc_next = fa_s;
      end else begin : g_acc_wn
         assign acc_next = {fa_s, acc[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.b;
                  carry <= 1'b0;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               carry <= fa_c;
               acc   <= acc_next;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + CNT_W'(1);
               // Result registers only change here, so partial sums never show.
               if (cnt == CNT_LAST) begin
                  sum_q  <= acc_next;
                  cout_q <= fa_c;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = (state == S_RUN);
   assign bus.done = (state == S_DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl

module tb_serial_adder_ctrl;

   logic clk;
   logic reset;

   int n_checks;
   int n_errors;

   logic [3:0] last_sum;
   logic       last_cout;

   serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();
   serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with dut4 idle; returns at a negedge with dut4 idle,
   // so back-to-back calls exercise the earliest-next-acceptance edge.
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] es, input logic ec);
      bus4.start = 1'b1;
      bus4.a     = a;
      bus4.b     = b;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a     = ~a;
      bus4.b     = ~b;
      for (int i = 0; i < 4; i++) begin
         check_val({tag, "_busy"},     32'(bus4.busy), 32'd1);
         check_val({tag, "_done_low"}, 32'(bus4.done), 32'd0);
         check_val({tag, "_sum_hold"}, 32'(bus4.sum),  32'(last_sum));
         @(negedge clk);
      end
      check_val({tag, "_done"},      32'(bus4.done), 32'd1);
      check_val({tag, "_busy_low"},  32'(bus4.busy), 32'd0);
      check_val({tag, "_sum"},       32'(bus4.sum),  32'(es));
      check_val({tag, "_cout"},      32'(bus4.cout), 32'(ec));
      last_sum  = es;
      last_cout = ec;
      @(negedge clk);
      check_val({tag, "_done_width"}, 32'(bus4.done), 32'd0);
      check_val({tag, "_sum_kept"},   32'(bus4.sum),  32'(es));
   endtask

   initial begin
      int n_done;
      int last_done;
      logic [3:0] hold;

      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b1;
      bus4.start = 1'b0;
      bus4.a     = '0;
      bus4.b     = '0;
      bus1.start = 1'b0;
      bus1.a     = '0;
      bus1.b     = '0;
      last_sum   = '0;
      last_cout  = 1'b0;

      repeat (2) @(negedge clk);
      check_val("rst_busy", 32'(bus4.busy), 32'd0);
      check_val("rst_done", 32'(bus4.done), 32'd0);
      check_val("rst_sum",  32'(bus4.sum),  32'd0);
      check_val("rst_cout", 32'(bus4.cout), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("add_3_5",   4'd3,  4'd5,  4'd8,  1'b0);
      run_op("add_15_1",  4'd15, 4'd1,  4'd0,  1'b1);
      run_op("add_15_15", 4'd15, 4'd15, 4'd14, 1'b1);
      run_op("add_0_0",   4'd0,  4'd0,  4'd0,  1'b0);

      // Second start two cycles into RUN must be dropped, not queued.
      bus4.start = 1'b1; bus4.a = 4'd6; bus4.b = 4'd7;
      @(negedge clk);
      bus4.start = 1'b0;
      @(negedge clk);
      bus4.start = 1'b1; bus4.a = 4'd1; bus4.b = 4'd1;
      @(negedge clk);
      bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus4.done) begin
            n_done++;
            check_val("ign_sum",  32'(bus4.sum),  32'd13);
            check_val("ign_cout", 32'(bus4.cout), 32'd0);
         end
         @(negedge clk);
      end
      check_val("ign_done_count", 32'(n_done), 32'd1);
      check_val("ign_idle_after", 32'(bus4.busy), 32'd0);
      last_sum = 4'd13;

      // Reset on the second RUN cycle aborts without a done pulse.
      bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd9;
      @(negedge clk);
      bus4.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("mid_rst_busy", 32'(bus4.busy), 32'd0);
      check_val("mid_rst_done", 32'(bus4.done), 32'd0);
      check_val("mid_rst_sum",  32'(bus4.sum),  32'd0);
      check_val("mid_rst_cout", 32'(bus4.cout), 32'd0);
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus4.done) n_done++;
      end
      check_val("mid_rst_no_done", 32'(n_done), 32'd0);
      last_sum = '0;

      // start held high: one operation every WIDTH+2 cycles.
      bus4.start = 1'b1; bus4.a = 4'd2; bus4.b = 4'd3;
      n_done    = 0;
      last_done = -1;
      hold      = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus4.done) begin
            n_done++;
            check_val("held_sum", 32'(bus4.sum), 32'd5);
            if (last_done >= 0) check_val("held_gap", 32'(i - last_done), 32'd6);
            last_done = i;
            hold = 4'd5;
         end else if (bus4.busy) begin
            check_val("held_sum_stable", 32'(bus4.sum), 32'(hold));
         end
      end
      check_val("held_done_count", 32'(n_done), 32'd3);
      bus4.start = 1'b0;
      repeat (8) @(negedge clk);

      // WIDTH=1 instance.
      bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
      check_val("w1_busy",     32'(bus1.busy), 32'd1);
      check_val("w1_done_low", 32'(bus1.done), 32'd0);
      @(negedge clk);
      check_val("w1_done",     32'(bus1.done), 32'd1);
      check_val("w1_busy_low", 32'(bus1.busy), 32'd0);
      check_val("w1_sum",      32'(bus1.sum),  32'd0);
      check_val("w1_cout",     32'(bus1.cout), 32'd1);
      @(negedge clk);
      check_val("w1_done_width", 32'(bus1.done), 32'd0);
      bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;
      @(negedge clk);
      bus1.start = 1'b0;
      @(negedge clk);
      check_val("w1b_done", 32'(bus1.done), 32'd1);
      check_val("w1b_sum",  32'(bus1.sum),  32'd1);
      check_val("w1b_cout", 32'(bus1.cout), 32'd0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
